// File: rtl/multicycle_exec_unit_pkg.sv
// isa_pkg: shared ISA definitions for the multi-cycle execute core.
//   opcode_t     - 4-bit opcode field (byte0[7:4]); unlisted values run as NOP
//   instr_t      - 16-bit instruction {opcode, rd, byte1}, byte1 = imm8 or {rs1, rs2}
//   exec_state_t - fetch/execute sequencer states
package isa_pkg;

  typedef enum logic [3:0] {
    NOP   = 4'h0,
    MOVIR = 4'h1,
    ADDRR = 4'h2,
    SUBRR = 4'h3,
    JZI   = 4'h4,
    JCI   = 4'h5,
    JMPI  = 4'h6,
    LDI   = 4'h7,
    STI   = 4'h8,
    HALT  = 4'h9
  } opcode_t;

  typedef struct packed {
    opcode_t    opcode;
    logic [3:0] rd;
    logic [7:0] byte1;
  } instr_t;

  typedef enum logic [2:0] {
    FETCH_HI,
    FETCH_LO,
    EXECUTE,
    MEM_ACCESS,
    HALTED
  } exec_state_t;

endpackage

// File: rtl/multicycle_exec_unit_alu.sv
// exec_alu: combinational add/subtract unit.
//   op     - opcode; only ADDRR and SUBRR produce a meaningful result
//   a, b   - operands (rs1, rs2)
//   result - (a op b) mod 2^DATA_BITS
//   z      - result is zero
//   c      - carry-out for ADDRR, borrow (a < b unsigned) for SUBRR
module exec_alu
  import isa_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8
) (
  input  opcode_t              op,
  input  logic [DATA_BITS-1:0] a,
  input  logic [DATA_BITS-1:0] b,
  output logic [DATA_BITS-1:0] result,
  output logic                 z,
  output logic                 c
);

  // One extra bit holds the carry; for subtraction it goes high exactly on borrow.
  logic [DATA_BITS:0] wide;

  always_comb begin
    wide = '0;
    case (op)
      ADDRR:   wide = {1'b0, a} + {1'b0, b};
      SUBRR:   wide = {1'b0, a} - {1'b0, b};
      default: wide = '0;
    endcase
    result = wide[DATA_BITS-1:0];
    c      = wide[DATA_BITS];
    z      = (result == '0);
  end

endmodule

// File: rtl/multicycle_exec_unit.sv
// multicycle_exec_unit: multi-cycle fetch/execute core, 16 x DATA_BITS registers,
// byte-wide external memory over a req/ack handshake.
//   clk, reset            - clock, synchronous active-high reset
//   mem_req/we/addr/wdata - memory request, held until mem_ack
//   mem_rdata, mem_ack    - read data and completion of the current request
//   dbg_reg_sel/data      - combinational register read port
//   pc, flag_z, flag_c    - architectural state
//   instr_done            - one-cycle pulse per retired instruction
//   halted                - high while in HALTED
module multicycle_exec_unit
  import isa_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [7:0]           mem_wdata,
  input  logic [7:0]           mem_rdata,
  input  logic                 mem_ack,
  input  logic [3:0]           dbg_reg_sel,
  output logic [DATA_BITS-1:0] dbg_reg_data,
  output logic [ADDR_BITS-1:0] pc,
  output logic                 flag_z,
  output logic                 flag_c,
  output logic                 instr_done,
  output logic                 halted
);

  exec_state_t          state_q, state_d;
  instr_t               ir;
  logic [DATA_BITS-1:0] regs [16];

  logic [ADDR_BITS-1:0] pc_plus1, pc_plus2, imm_addr;
  logic [DATA_BITS-1:0] alu_result;
  logic                 alu_z, alu_c;

  assign pc_plus1 = pc + ADDR_BITS'(1);
  assign pc_plus2 = pc + ADDR_BITS'(2);
  assign imm_addr = ADDR_BITS'(ir.byte1);

  always_comb dbg_reg_data = regs[dbg_reg_sel];

  exec_alu #(.DATA_BITS(DATA_BITS)) u_alu (
    .op     (ir.opcode),
    .a      (regs[ir.byte1[7:4]]),
    .b      (regs[ir.byte1[3:0]]),
    .result (alu_result),
    .z      (alu_z),
    .c      (alu_c)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH_HI;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    instr_done = 1'b0;
    halted     = 1'b0;
    case (state_q)
      FETCH_HI: begin
        mem_req  = 1'b1;
        mem_addr = pc;
        if (mem_ack) state_d = FETCH_LO;
      end
      FETCH_LO: begin
        mem_req  = 1'b1;
        mem_addr = pc_plus1;
        if (mem_ack) state_d = EXECUTE;
      end
      EXECUTE: begin
        case (ir.opcode)
          LDI, STI: state_d = MEM_ACCESS;
          HALT: begin
            instr_done = 1'b1;
            state_d    = HALTED;
          end
          default: begin
            instr_done = 1'b1;
            state_d    = FETCH_HI;
          end
        endcase
      end
      MEM_ACCESS: begin
        mem_req  = 1'b1;
        mem_addr = imm_addr;
        if (ir.opcode == STI) begin
          mem_we    = 1'b1;
          mem_wdata = regs[ir.rd][7:0];
        end
        if (mem_ack) begin
          instr_done = 1'b1;
          state_d    = FETCH_HI;
        end
      end
      HALTED:  halted = 1'b1;
      default: state_d = FETCH_HI;
    endcase
    // Outputs are decoded from state, so reset must mask them to drop an
    // in-flight request in the same cycle reset is seen.
    if (reset) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      instr_done = 1'b0;
      halted     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      ir     <= '0;
      for (int unsigned i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      case (state_q)
        FETCH_HI: if (mem_ack) begin
          ir.opcode <= opcode_t'(mem_rdata[7:4]);
          ir.rd     <= mem_rdata[3:0];
        end
        FETCH_LO: if (mem_ack) ir.byte1 <= mem_rdata;
        EXECUTE: begin
          case (ir.opcode)
            MOVIR: begin
              regs[ir.rd] <= DATA_BITS'(ir.byte1);
              pc          <= pc_plus2;
            end
            ADDRR, SUBRR: begin
              regs[ir.rd] <= alu_result;
              flag_z      <= alu_z;
              flag_c      <= alu_c;
              pc          <= pc_plus2;
            end
            JZI:  pc <= flag_z ? imm_addr : pc_plus2;
            JCI:  pc <= flag_c ? imm_addr : pc_plus2;
            JMPI: pc <= imm_addr;
            LDI, STI, HALT: ;
            default: pc <= pc_plus2;
          endcase
        end
        MEM_ACCESS: if (mem_ack) begin
          if (ir.opcode == LDI) regs[ir.rd] <= DATA_BITS'(mem_rdata);
          pc <= pc_plus2;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_exec_unit.sv
module tb_multicycle_exec_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  // ---------------- 8-bit instance with configurable-latency memory
  logic       reset8;
  logic       mem_req8, mem_we8, ack8;
  logic [7:0] mem_addr8, mem_wdata8, rdata8;
  logic [3:0] dbg_sel8;
  logic [7:0] dbg_data8, pc8;
  logic       z8, c8, done8, halted8;
  logic [7:0] mem8 [256];
  logic       rand_mode = 1'b0;
  logic       hold_ack = 1'b0;
  int unsigned wait8 = 0;

  assign rdata8 = mem8[mem_addr8];
  assign ack8   = mem_req8 && !hold_ack && (wait8 == 0);

  multicycle_exec_unit #(.DATA_BITS(8), .ADDR_BITS(8)) dut8 (
    .clk(clk), .reset(reset8),
    .mem_req(mem_req8), .mem_we(mem_we8), .mem_addr(mem_addr8), .mem_wdata(mem_wdata8),
    .mem_rdata(rdata8), .mem_ack(ack8),
    .dbg_reg_sel(dbg_sel8), .dbg_reg_data(dbg_data8),
    .pc(pc8), .flag_z(z8), .flag_c(c8), .instr_done(done8), .halted(halted8)
  );

  always @(posedge clk) begin
    if (mem_req8 && ack8) begin
      if (mem_we8) mem8[mem_addr8] <= mem_wdata8;
      wait8 <= rand_mode ? $urandom_range(5, 0) : 0;
    end else if (mem_req8 && wait8 != 0) begin
      wait8 <= wait8 - 1;
    end
  end

  // ---------------- 16-bit instance with zero-wait memory
  logic        reset16;
  logic        mem_req16, mem_we16;
  logic [7:0]  mem_addr16, mem_wdata16, rdata16;
  logic [3:0]  dbg_sel16;
  logic [15:0] dbg_data16;
  logic [7:0]  pc16;
  logic        z16, c16, done16, halted16;
  logic [7:0]  mem16 [256];

  assign rdata16 = mem16[mem_addr16];

  multicycle_exec_unit #(.DATA_BITS(16), .ADDR_BITS(8)) dut16 (
    .clk(clk), .reset(reset16),
    .mem_req(mem_req16), .mem_we(mem_we16), .mem_addr(mem_addr16), .mem_wdata(mem_wdata16),
    .mem_rdata(rdata16), .mem_ack(mem_req16),
    .dbg_reg_sel(dbg_sel16), .dbg_reg_data(dbg_data16),
    .pc(pc16), .flag_z(z16), .flag_c(c16), .instr_done(done16), .halted(halted16)
  );

  always @(posedge clk) begin
    if (mem_req16 && mem_we16) mem16[mem_addr16] <= mem_wdata16;
  end

  // ---------------- monitors (sample pre-edge DUT values)
  int unsigned cyc = 0;
  int unsigned done_cyc8[$];
  int unsigned done_cnt16 = 0;
  int unsigned we_cycles8 = 0;
  int unsigned stab_viol = 0;
  int unsigned exec_req_viol = 0;
  logic        pend8 = 1'b0, pwe8 = 1'b0;
  logic [7:0]  paddr8 = '0;

  always @(posedge clk) begin
    if (done8) done_cyc8.push_back(cyc);
    if (done16) done_cnt16 = done_cnt16 + 1;
    if (mem_req8 && mem_we8) we_cycles8 = we_cycles8 + 1;
    if (done8 && mem_req8) exec_req_viol = exec_req_viol + 1;
    if (pend8 && !reset8 && (!mem_req8 || mem_addr8 != paddr8 || mem_we8 != pwe8))
      stab_viol = stab_viol + 1;
    pend8  = mem_req8 && !ack8 && !reset8;
    paddr8 = mem_addr8;
    pwe8   = mem_we8;
    cyc    = cyc + 1;
  end

  int unsigned cyc0;

  task automatic load_prog1();
    for (int i = 0; i < 256; i++) mem8[i] <= 8'h00;
    mem8[0] <= 8'h17; mem8[1] <= 8'hFE;   // MOVIR r7,254
    mem8[2] <= 8'h11; mem8[3] <= 8'h36;   // MOVIR r1,54
    mem8[4] <= 8'h33; mem8[5] <= 8'h71;   // SUBRR r3,r7,r1
    mem8[6] <= 8'h33; mem8[7] <= 8'h17;   // SUBRR r3,r1,r7
    mem8[8] <= 8'h50; mem8[9] <= 8'h20;   // JCI 0x20
    mem8[32] <= 8'h90; mem8[33] <= 8'h00; // HALT
  endtask

  task automatic restart8();
    reset8 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    done_cyc8.delete();
    we_cycles8 = 0; stab_viol = 0; exec_req_viol = 0;
    cyc0 = cyc;
    reset8 = 1'b0;
  endtask

  task automatic wait_done8(input int unsigned n, input int unsigned budget, input string tag);
    int unsigned k = 0;
    while (done_cyc8.size() < n && k < budget) begin
      @(posedge clk); #1; k++;
    end
    if (done_cyc8.size() < n) begin
      n_total++;
      $display("FAIL %s_timeout: retired %0d required %0d", tag, done_cyc8.size(), n);
    end
  endtask

  task automatic get_reg8(input logic [3:0] r, output logic [7:0] v);
    dbg_sel8 = r; #1; v = dbg_data8;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    reset8 = 1'b1; reset16 = 1'b1;
    for (int i = 0; i < 256; i++) begin mem8[i] <= 8'h00; mem16[i] <= 8'h00; end
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (mem_req8 !== 1'b0) $display("FAIL rst_req: got %b expected 0", mem_req8); else n_pass++;
    n_total++; if (mem_we8 !== 1'b0) $display("FAIL rst_we: got %b expected 0", mem_we8); else n_pass++;
    n_total++; if (mem_addr8 !== 8'h00) $display("FAIL rst_addr: got %h expected 00", mem_addr8); else n_pass++;
    n_total++; if (mem_wdata8 !== 8'h00) $display("FAIL rst_wdata: got %h expected 00", mem_wdata8); else n_pass++;
    n_total++; if (pc8 !== 8'h00) $display("FAIL rst_pc: got %h expected 00", pc8); else n_pass++;
    n_total++; if ({z8, c8, done8, halted8} !== 4'b0000) $display("FAIL rst_status: got %b expected 0000", {z8, c8, done8, halted8}); else n_pass++;
    get_reg8(4'd5, v);
    n_total++; if (v !== 8'h00) $display("FAIL rst_r5: got %h expected 00", v); else n_pass++;
    n_total++; if ({mem_req16, pc16} !== 9'h000) $display("FAIL rst_16: got %h expected 000", {mem_req16, pc16}); else n_pass++;
  endtask

  task automatic test_zero_wait();
    logic [7:0] v;
    rand_mode = 1'b0; hold_ack = 1'b0;
    reset8 = 1'b1; load_prog1();
    restart8();
    wait_done8(3, 40, "zw3");
    n_total++; if (pc8 !== 8'd6) $display("FAIL zw_pc: got %0d expected 6", pc8); else n_pass++;
    n_total++; if ({z8, c8} !== 2'b00) $display("FAIL zw_flags: got %b expected 00", {z8, c8}); else n_pass++;
    get_reg8(4'd3, v);
    n_total++; if (v !== 8'd200) $display("FAIL zw_r3: got %0d expected 200", v); else n_pass++;
    if (done_cyc8.size() >= 3) begin
      n_total++; if (done_cyc8[0] - cyc0 !== 2) $display("FAIL zw_first_latency: got %0d expected 2", done_cyc8[0] - cyc0); else n_pass++;
      n_total++; if (done_cyc8[1] - done_cyc8[0] !== 3) $display("FAIL zw_gap1: got %0d expected 3", done_cyc8[1] - done_cyc8[0]); else n_pass++;
      n_total++; if (done_cyc8[2] - done_cyc8[1] !== 3) $display("FAIL zw_gap2: got %0d expected 3", done_cyc8[2] - done_cyc8[1]); else n_pass++;
    end
    wait_done8(5, 40, "zw5");
    n_total++; if (pc8 !== 8'h20) $display("FAIL jci_pc: got %h expected 20", pc8); else n_pass++;
    n_total++; if ({z8, c8} !== 2'b01) $display("FAIL jci_flags: got %b expected 01", {z8, c8}); else n_pass++;
    get_reg8(4'd3, v);
    n_total++; if (v !== 8'd56) $display("FAIL sub_borrow_r3: got %0d expected 56", v); else n_pass++;
  endtask

  task automatic test_halt8();
    int unsigned k = 0;
    int unsigned reqs = 0;
    while (!halted8 && k < 20) begin @(posedge clk); #1; k++; end
    n_total++; if (halted8 !== 1'b1) $display("FAIL halt8: got %b expected 1", halted8); else n_pass++;
    repeat (5) begin
      if (mem_req8) reqs++;
      @(posedge clk); #1;
    end
    n_total++; if (reqs !== 0) $display("FAIL halt8_noreq: got %0d request cycles expected 0", reqs); else n_pass++;
    n_total++; if (pc8 !== 8'h20) $display("FAIL halt8_pc: got %h expected 20", pc8); else n_pass++;
  endtask

  task automatic test_random_wait();
    logic [7:0] v;
    rand_mode = 1'b1; hold_ack = 1'b0;
    reset8 = 1'b1; load_prog1();
    restart8();
    wait_done8(5, 300, "rnd");
    n_total++; if (pc8 !== 8'h20) $display("FAIL rnd_pc: got %h expected 20", pc8); else n_pass++;
    n_total++; if ({z8, c8} !== 2'b01) $display("FAIL rnd_flags: got %b expected 01", {z8, c8}); else n_pass++;
    get_reg8(4'd3, v);
    n_total++; if (v !== 8'd56) $display("FAIL rnd_r3: got %0d expected 56", v); else n_pass++;
    get_reg8(4'd7, v);
    n_total++; if (v !== 8'd254) $display("FAIL rnd_r7: got %0d expected 254", v); else n_pass++;
    get_reg8(4'd1, v);
    n_total++; if (v !== 8'd54) $display("FAIL rnd_r1: got %0d expected 54", v); else n_pass++;
    n_total++; if (stab_viol !== 0) $display("FAIL rnd_stable: got %0d violations expected 0", stab_viol); else n_pass++;
    n_total++; if (exec_req_viol !== 0) $display("FAIL rnd_exec_req: got %0d expected 0", exec_req_viol); else n_pass++;
    rand_mode = 1'b0;
  endtask

  task automatic test_sti_ldi();
    logic [7:0] v;
    rand_mode = 1'b0; hold_ack = 1'b0;
    reset8 = 1'b1;
    for (int i = 0; i < 256; i++) mem8[i] <= 8'h00;
    mem8[0] <= 8'h17; mem8[1] <= 8'hFE;   // MOVIR r7,254
    mem8[2] <= 8'h87; mem8[3] <= 8'h40;   // STI r7,0x40
    mem8[4] <= 8'h72; mem8[5] <= 8'h40;   // LDI r2,0x40
    mem8[6] <= 8'h90; mem8[7] <= 8'h00;   // HALT
    restart8();
    wait_done8(3, 40, "mem");
    n_total++; if (pc8 !== 8'd6) $display("FAIL mem_pc: got %0d expected 6", pc8); else n_pass++;
    n_total++; if (mem8[8'h40] !== 8'd254) $display("FAIL sti_byte: got %0d expected 254", mem8[8'h40]); else n_pass++;
    get_reg8(4'd2, v);
    n_total++; if (v !== 8'd254) $display("FAIL ldi_r2: got %0d expected 254", v); else n_pass++;
    n_total++; if (we_cycles8 !== 1) $display("FAIL sti_we_cycles: got %0d expected 1", we_cycles8); else n_pass++;
    if (done_cyc8.size() >= 3) begin
      n_total++; if (done_cyc8[1] - done_cyc8[0] !== 4) $display("FAIL sti_gap: got %0d expected 4", done_cyc8[1] - done_cyc8[0]); else n_pass++;
      n_total++; if (done_cyc8[2] - done_cyc8[1] !== 4) $display("FAIL ldi_gap: got %0d expected 4", done_cyc8[2] - done_cyc8[1]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    int unsigned nonzero = 0;
    rand_mode = 1'b0; hold_ack = 1'b0;
    reset8 = 1'b1; load_prog1();
    restart8();
    wait_done8(3, 40, "rm");
    @(posedge clk); #1;
    hold_ack = 1'b1;
    n_total++; if ({mem_req8, mem_addr8} !== 9'h107) $display("FAIL rm_fetch_lo: got %h expected 107", {mem_req8, mem_addr8}); else n_pass++;
    @(posedge clk); #1;
    n_total++; if ({mem_req8, mem_addr8} !== 9'h107) $display("FAIL rm_held: got %h expected 107", {mem_req8, mem_addr8}); else n_pass++;
    reset8 = 1'b1; #1;
    n_total++; if (mem_req8 !== 1'b0) $display("FAIL rm_drop_req: got %b expected 0", mem_req8); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (pc8 !== 8'h00) $display("FAIL rm_pc: got %h expected 00", pc8); else n_pass++;
    n_total++; if ({z8, c8, done8} !== 3'b000) $display("FAIL rm_status: got %b expected 000", {z8, c8, done8}); else n_pass++;
    for (int r = 0; r < 16; r++) begin
      get_reg8(4'(r), v);
      if (v != 8'h00) nonzero++;
    end
    n_total++; if (nonzero !== 0) $display("FAIL rm_regs: got %0d nonzero regs expected 0", nonzero); else n_pass++;
    hold_ack = 1'b0;
    @(posedge clk); #1;
    done_cyc8.delete();
    reset8 = 1'b0; #1;
    n_total++; if ({mem_req8, mem_addr8} !== 9'h100) $display("FAIL rm_restart: got %h expected 100", {mem_req8, mem_addr8}); else n_pass++;
    wait_done8(1, 20, "rm_first");
    get_reg8(4'd7, v);
    n_total++; if ({pc8, v} !== {8'd2, 8'd254}) $display("FAIL rm_first_instr: got pc %0d r7 %0d expected pc 2 r7 254", pc8, v); else n_pass++;
  endtask

  task automatic test_wide16();
    int unsigned k = 0;
    int unsigned reqs = 0;
    reset16 = 1'b1;
    for (int i = 0; i < 256; i++) mem16[i] <= 8'h00;
    mem16[0] <= 8'h11; mem16[1] <= 8'h01;   // MOVIR r1,1
    mem16[2] <= 8'h12; mem16[3] <= 8'h02;   // MOVIR r2,2
    mem16[4] <= 8'h33; mem16[5] <= 8'h12;   // SUBRR r3,r1,r2
    mem16[6] <= 8'h60; mem16[7] <= 8'hFE;   // JMPI 0xFE; NOP at 0xFE
    repeat (2) @(posedge clk);
    #1;
    done_cnt16 = 0;
    reset16 = 1'b0;
    while (done_cnt16 < 4 && k < 40) begin @(posedge clk); #1; k++; end
    n_total++; if (pc16 !== 8'hFE) $display("FAIL w16_jmp_pc: got %h expected FE", pc16); else n_pass++;
    while (done_cnt16 < 5 && k < 40) begin @(posedge clk); #1; k++; end
    n_total++; if (pc16 !== 8'h00) $display("FAIL w16_wrap_pc: got %h expected 00", pc16); else n_pass++;
    n_total++; if ({z16, c16} !== 2'b01) $display("FAIL w16_flags: got %b expected 01", {z16, c16}); else n_pass++;
    mem16[0] <= 8'h90; mem16[1] <= 8'h00;   // replace the instruction at 0 with HALT
    dbg_sel16 = 4'd3; #1;
    n_total++; if (dbg_data16 !== 16'hFFFF) $display("FAIL w16_r3: got %h expected FFFF", dbg_data16); else n_pass++;
    k = 0;
    while (!halted16 && k < 20) begin @(posedge clk); #1; k++; end
    n_total++; if (halted16 !== 1'b1) $display("FAIL w16_halt: got %b expected 1", halted16); else n_pass++;
    repeat (5) begin
      if (mem_req16) reqs++;
      @(posedge clk); #1;
    end
    n_total++; if (reqs !== 0) $display("FAIL w16_noreq: got %0d request cycles expected 0", reqs); else n_pass++;
  endtask

  initial begin
    reset8 = 1'b1; reset16 = 1'b1;
    dbg_sel8 = '0; dbg_sel16 = '0;
    test_reset();
    test_zero_wait();
    test_halt8();
    test_random_wait();
    test_sti_ldi();
    test_reset_mid();
    test_wide16();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, limit 200000", $time);
    $fatal(1);
  end

endmodule
